// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the byte-serial instruction loader.
// Byte lanes are big-endian: the first byte of a word lands in bits [31:24].
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  // LSB position of byte lane idx, where lane 0 is the first byte received.
  function automatic int lane_lsb(input int idx);
    return WORD_W - BYTE_W * (idx + 1);
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs four serial bytes into one big-endian word.
// o_word already includes the byte being accepted this cycle, so the parent can capture it on the 4th byte.
module instr_loader_byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_full
);

  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_next;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      localparam int LSB = lane_lsb(gi);
      assign w_word_next[LSB +: BYTE_W] = (i_accept && (r_idx == 2'(gi))) ? i_byte
                                                                         : r_word[LSB +: BYTE_W];
    end
  endgenerate

  assign o_word = w_word_next;
  assign o_full = i_accept && (r_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= w_word_next;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-serial program loader: packs a byte stream into 32-bit words and writes them
// to consecutive word addresses of the instruction memory while stalling the CPU.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 128,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_base;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_words_written;
  logic               r_busy;
  logic               r_err;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;

  logic               w_accept;
  logic               w_full;
  logic [31:0]        w_packed;
  logic [ADDR_W+1:0]  w_end;
  logic               w_illegal;
  logic [CNT_W-1:0]   w_written_inc;

  // End address is formed two bits wider than the address so it can never wrap.
  assign w_end         = {2'b00, base_addr} + (ADDR_W + 2)'({word_count, 2'b00});
  assign w_illegal     = (base_addr[1:0] != 2'b00) || (w_end > (ADDR_W + 2)'(MEM_BYTES));
  assign w_accept      = in_valid && in_ready;
  assign w_written_inc = r_words_written + CNT_W'(1);

  instr_loader_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state == IDLE),
    .i_accept (w_accept),
    .i_byte   (in_byte),
    .o_word   (w_packed),
    .o_full   (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start && !w_illegal) begin
          w_state_next = (word_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (w_full) begin
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_state_next = (w_written_inc == r_count) ? DONE : RECV;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == RECV);
    mem_we   = (r_state == WRITE);
    done     = (r_state == DONE);
  end

  // Address and data are captured on the 4th byte so they are stable throughout WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base          <= '0;
      r_count         <= '0;
      r_words_written <= '0;
      r_busy          <= 1'b0;
      r_err           <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_err <= w_illegal;
            if (!w_illegal) begin
              r_base          <= base_addr;
              r_count         <= word_count;
              r_words_written <= '0;
              r_busy          <= (word_count != '0);
            end
          end
        end
        RECV: begin
          if (w_full) begin
            r_mem_addr  <= r_base + ADDR_W'({r_words_written, 2'b00});
            r_mem_wdata <= w_packed;
          end
        end
        WRITE: begin
          r_words_written <= w_written_inc;
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign cpu_hold  = r_busy;
  assign err       = r_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized byte streams with bubbles, checked
// against a word-level model of the expected writes, done timing and error flag.
module tb_instr_loader;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 128;
  localparam int CNT_W     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;

  instr_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every write and done pulse seen on the bus.
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int done_cnt  = 0;
  int done_cyc  = 0;
  int ready_cnt = 0;
  int hold_bad  = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (in_ready === 1'b1) ready_cnt++;
    if (cpu_hold !== busy) hold_bad++;
  end

  // Stream to present: bytes and idle gap (in ready cycles) before each byte.
  logic [7:0] pb[$];
  int         gp[$];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    done_cnt  = 0;
    done_cyc  = 0;
    ready_cnt = 0;
    hold_bad  = 0;
  endtask

  task automatic fill_stream(input int nbytes, input int maxgap);
    pb.delete();
    gp.delete();
    for (int i = 0; i < nbytes; i++) begin
      pb.push_back(8'($urandom));
      gp.push_back(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic run_load(input logic [31:0] base, input logic [7:0] count, input string name);
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          legal;
    int          start_cyc, exp_done, gap_sum, i, g, budget, busy_bad, nb;
    nb    = 4 * int'(count);
    legal = (base[1:0] == 2'b00) && ((longint'(base) + 4 * longint'(count)) <= MEM_BYTES);
    gap_sum = 0;
    if (legal) begin
      for (int k = 0; k < int'(count); k++) begin
        exp_addr.push_back(base + 32'(4 * k));
        exp_data.push_back({pb[4*k], pb[4*k+1], pb[4*k+2], pb[4*k+3]});
      end
      for (int k = 0; k < nb; k++) gap_sum += gp[k];
    end
    exp_done = 5 * int'(count) + 1 + gap_sum;

    clear_mon();
    tick();
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    start_cyc  = cyc;
    i          = 0;
    g          = (legal && nb > 0) ? gp[0] : 0;
    budget     = 0;
    busy_bad   = 0;
    while (legal && i < nb && budget < 1000) begin
      tick();
      start = 1'b0;
      budget++;
      if (busy !== 1'b1) busy_bad++;
      if (in_ready === 1'b1) begin
        if (g > 0) begin
          in_valid = 1'b0;
          g--;
        end else begin
          in_valid = 1'b1;
          in_byte  = pb[i];
          i++;
          if (i < nb) g = gp[i];
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_byte  = 8'($urandom);
      end
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    if (legal) begin
      budget = 0;
      while (done_cnt == 0 && budget < 60) begin
        tick();
        budget++;
      end
    end else begin
      repeat (4) tick();
    end

    n_tests++;
    if (legal && (done_cnt != 1 || done_cyc - start_cyc != exp_done)) begin
      n_fail++;
      $display("FAIL %s done: count=%0d at cycle %0d, required 1 at cycle %0d", name, done_cnt,
               done_cyc - start_cyc, exp_done);
    end
    if (!legal && done_cnt != 0) begin
      n_fail++;
      $display("FAIL %s done: %0d pulses, required 0", name, done_cnt);
    end
    n_tests++;
    if (err !== !legal) begin
      n_fail++;
      $display("FAIL %s err: got %b, required %b", name, err, !legal);
    end
    n_tests++;
    if (got_addr.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL %s write count: got %0d, required %0d", name, got_addr.size(), exp_addr.size());
    end else begin
      for (int k = 0; k < exp_addr.size(); k++) begin
        n_tests++;
        if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
          n_fail++;
          $display("FAIL %s write %0d: got %h@%h, required %h@%h", name, k, got_data[k],
                   got_addr[k], exp_data[k], exp_addr[k]);
        end
      end
    end
    n_tests++;
    if (busy_bad != 0 || hold_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy/hold: %0d busy-low cycles, %0d hold mismatches, required 0/0",
               name, busy_bad, hold_bad);
    end
    if (!legal || count == 0) begin
      n_tests++;
      if (ready_cnt != 0) begin
        n_fail++;
        $display("FAIL %s in_ready: high %0d cycles, required 0", name, ready_cnt);
      end
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle busy: got %b/%b, required 0/0", name, busy, cpu_hold);
    end
    $display("[TB] %s base=%0d count=%0d legal=%0b writes=%0d done_at=%0d", name, base, count,
             legal, got_addr.size(), done_cyc - start_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    clear_mon();
    repeat (3) tick();
    n_tests++;
    if ({in_ready, mem_we, busy, done, err, cpu_hold} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset flags: got %b, required 000000",
               {in_ready, mem_we, busy, done, err, cpu_hold});
    end
    n_tests++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset bus: got %h@%h, required 0@0", mem_wdata, mem_addr);
    end
    n_tests++;
    if (got_addr.size() != 0 || ready_cnt != 0) begin
      n_fail++;
      $display("FAIL reset idle: %0d writes %0d ready cycles, required 0/0", got_addr.size(), ready_cnt);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    pb = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
    gp = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_load(32'd0, 8'd2, "basic");
  endtask

  task automatic test_bubbles();
    pb = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
    gp = '{0, 0, 3, 0, 0, 0, 0, 0};
    run_load(32'd0, 8'd2, "bubbles");
  endtask

  task automatic test_illegal();
    fill_stream(8, 0);
    run_load(32'd2, 8'd1, "misaligned");
    run_load(32'd124, 8'd2, "overflow");
    fill_stream(4, 1);
    run_load(32'd124, 8'd1, "last_word");
  endtask

  task automatic test_zero_count();
    pb.delete();
    gp.delete();
    run_load(32'd0, 8'd0, "zero_count");
  endtask

  task automatic test_reset_mid_word();
    clear_mon();
    tick();
    start = 1'b1; base_addr = 32'd8; word_count = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_byte = 8'hAA;
    tick();
    in_byte = 8'hBB;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (got_addr.size() != 0 || busy !== 1'b0 || in_ready !== 1'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL mid_reset: writes=%0d busy=%b in_ready=%b done=%0d, required 0/0/0/0",
               got_addr.size(), busy, in_ready, done_cnt);
    end
    $display("[TB] mid_reset abandoned load, writes=%0d", got_addr.size());
    fill_stream(4, 1);
    run_load(32'd8, 8'd1, "after_reset");
  endtask

  task automatic test_back_to_back();
    int cnt, b;
    for (int n = 0; n < 6; n++) begin
      cnt = int'($urandom_range(1, 4));
      b   = 4 * int'($urandom_range(0, 32 - cnt));
      fill_stream(4 * cnt, 2);
      run_load(32'(b), 8'(cnt), "random");
    end
    fill_stream(128, 1);
    run_load(32'd0, 8'd32, "full_mem");
    for (int n = 0; n < 3; n++) begin
      b   = 4 * int'($urandom_range(28, 31));
      cnt = 32 - b / 4 + 1 + int'($urandom_range(0, 3));
      fill_stream(4 * cnt, 0);
      run_load(32'(b), 8'(cnt), "random_ovf");
      fill_stream(4, 0);
      run_load(32'd4, 8'd1, "recover");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; in_byte = '0; in_valid = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_illegal();
    test_zero_count();
    test_reset_mid_word();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Byte-serial program loader for the multicycle MIPS CPU.
- Accepts a stream of bytes over a valid/ready handshake and packs each group of four into a big-endian 32-bit instruction word (first byte -> [31:24]).
- Writes each word into the byte-addressed instruction memory at consecutive word addresses.
- It is the writer side of the instruction store that the fetch path reads; it holds the CPU stalled while loading.

Parameters:
- ADDR_W, 32, width of byte address and of base_addr/mem_addr
- MEM_BYTES, 128, instruction memory size in bytes (32 words)
- CNT_W, 8, width of word_count and internal word counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle load request, sampled only in IDLE
- base_addr  input  ADDR_W  first byte address of the load; latched on accepted start
- word_count  input  CNT_W  number of 32-bit words to load; latched on accepted start
- in_byte  input  8  incoming program byte
- in_valid  input  1  in_byte valid
- in_ready  output  1  loader can accept a byte this cycle
- mem_addr  output  ADDR_W  word-aligned byte address of the current write
- mem_wdata  output  32  assembled big-endian word
- mem_we  output  1  single-cycle write strobe
- busy  output  1  load in progress
- done  output  1  one-cycle pulse when the load completes
- err  output  1  sticky parameter error flag, cleared by the next accepted start
- cpu_hold  output  1  CPU stall request; equal to busy

Behaviour:
- Reset:
  - state=IDLE.
  - in_ready, mem_we, busy, done, err and cpu_hold are 0.
  - mem_addr and mem_wdata are 0.
  - Byte index and word counter are 0.
  - Reset mid-load abandons the load. A partially assembled word is never written.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start, err is cleared and then checked. The request is illegal if base_addr[1:0]!=0, or if base_addr + 4*word_count > MEM_BYTES (computed at ADDR_W+2 bits, no wrap).
  - Illegal request: err<=1, remain in IDLE, no writes.
  - Legal request with word_count==0: go to DONE.
  - Legal request otherwise: latch base and count, busy<=1, go to RECV.
- RECV:
  - in_ready=1.
  - A byte is accepted when in_valid&&in_ready; byte index 0..3 steers it to [31:24], [23:16], [15:8], [7:0].
  - Cycles with in_valid=0 leave the state unchanged.
  - The 4th accepted byte moves the state to WRITE on the next edge.
- WRITE:
  - in_ready=0; mem_we=1 for exactly this one cycle.
  - mem_addr = base + 4*words_written; mem_wdata = the assembled word.
  - words_written increments.
  - If words_written+1 == count, go to DONE; otherwise return to RECV with byte index 0.
- DONE:
  - done=1 for one cycle and busy<=0, then go to IDLE.
  - cpu_hold falls in the same cycle as busy.
- Outside WRITE, mem_addr and mem_wdata hold their last values and are only meaningful while mem_we=1.
- start is ignored while not in IDLE.
- Minimum throughput is 5 cycles per word: 4 byte cycles plus 1 write cycle.
- Total latency from an accepted start for N words with continuous valid is 5N+1 cycles to the done pulse.
- Registered outputs: busy, err, mem_addr, mem_wdata. Outputs decoded directly from state: in_ready, mem_we, done.

Decomposition:
- Shared package (instr_loader_pkg):
  - state enum {IDLE, RECV, WRITE, DONE}
  - BYTES_PER_WORD=4
  - byte-lane constants for big-endian placement
- Natural sub-module: byte_packer.
  - Contains the 2-bit byte index and the 32-bit shift/steer register.
  - Interface: clear, accept, in_byte -> word, full.
- The FSM, range check and address counter stay in instr_loader.

Test Plan:
1. Reset/default: assert rst for 3 cycles, then hold inputs at 0 -> all outputs 0, no mem_we, in_ready=0.
2. Basic load:
   - Stimulus: start with base=0, count=2; bytes 8C 01 00 04 20 02 00 05 presented with continuous in_valid.
   - Required response: mem_we at addr 0 with data 32'h8C010004; mem_we at addr 4 with data 32'h20020005; done on cycle 11 after start; busy/cpu_hold high between those points.
3. Bubbles: same load with in_valid low for 3 cycles between bytes 2 and 3 -> identical writes, done delayed by exactly 3 cycles.
4. Illegal parameters:
   - start base=2, count=1 -> err=1, no mem_we, busy stays 0.
   - start base=124, count=2 -> err=1.
   - A following legal start clears err.
5. Zero count: start base=0, count=0 -> done pulse one cycle later, no mem_we, in_ready never high.
6. Reset mid-word: after 2 bytes of the first word, assert rst -> no mem_we, state IDLE. A new load then writes a correct word at base.
